// File: rtl/locator_pkg.sv
// Shared types and default widths for the board cell locator.
package locator_pkg;
  localparam int XY_W_DEF  = 12;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIV_X,
    DIV_Y,
    DONE
  } state_t;
endpackage

// File: rtl/game_set_if.sv
// Board geometry bundle: the game setup drives it through out, the locator reads it through in.
interface game_set_if
  import locator_pkg::*;
#(
  parameter int XY_W  = XY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [XY_W-1:0]  board_xpos;
  logic [XY_W-1:0]  board_ypos;
  logic [XY_W-1:0]  board_size;
  logic [XY_W-1:0]  button_size;
  logic [CNT_W-1:0] button_num;

  modport out (output board_xpos, board_ypos, board_size, button_size, button_num);
  modport in  (input  board_xpos, board_ypos, board_size, button_size, button_num);
endinterface

// File: rtl/click_edge.sv
// Rising-edge detector for the mouse button level; pulse is combinational, one cycle per press.
// Built only with LOCATOR_EDGE_DETECT_EN; no backpressure, the pulse is dropped if the locator is busy.
`ifdef LOCATOR_EDGE_DETECT_EN
module click_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);
  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign pulse = level & ~level_q;
endmodule
`endif

// File: rtl/cell_locator.sv
// Maps a click position to board column/row by repeated subtraction; done at cycle col+row+4 (misses sooner).
// req is only taken in IDLE and dropped otherwise; LOCATOR_EDGE_DETECT_EN makes req a button level.
module cell_locator
  import locator_pkg::*;
#(
  parameter int XY_W  = XY_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  game_set_if.in           gin,
  input  logic [XY_W-1:0]  mouse_xpos,
  input  logic [XY_W-1:0]  mouse_ypos,
  input  logic             req,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row
);
  state_t state, state_d;
  logic   hit_d;
  logic   start;

  logic [XY_W-1:0]  mx_q, my_q, xpos_q, ypos_q, size_q, bsz_q;
  logic [XY_W-1:0]  rem_x, rem_y;
  logic [CNT_W-1:0] num_q, col_cnt, row_cnt;
  logic signed [XY_W:0] dx, dy;
  logic off_board, x_step, y_step, col_last, row_last;

`ifdef LOCATOR_EDGE_DETECT_EN
  click_edge u_click_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (req),
    .pulse (start)
  );
`else
  assign start = req;
`endif

  assign dx = $signed({1'b0, mx_q}) - $signed({1'b0, xpos_q});
  assign dy = $signed({1'b0, my_q}) - $signed({1'b0, ypos_q});

  assign off_board = dx[XY_W] | dy[XY_W]
                   | (dx >= $signed({1'b0, size_q}))
                   | (dy >= $signed({1'b0, size_q}))
                   | (bsz_q == '0) | (num_q == '0);

  assign x_step   = rem_x >= bsz_q;
  assign y_step   = rem_y >= bsz_q;
  // An index reaching button_num means the pointer is past the last button.
  assign col_last = ({1'b0, col_cnt} + (CNT_W+1)'(1)) == {1'b0, num_q};
  assign row_last = ({1'b0, row_cnt} + (CNT_W+1)'(1)) == {1'b0, num_q};

  always_comb begin
    state_d = state;
    hit_d   = 1'b0;
    case (state)
      IDLE:  if (start) state_d = CHECK;
      CHECK: state_d = off_board ? DONE : DIV_X;
      DIV_X: begin
        if (!x_step)       state_d = DIV_Y;
        else if (col_last) state_d = DONE;
      end
      DIV_Y: begin
        if (!y_step) begin
          state_d = DONE;
          hit_d   = 1'b1;
        end else if (row_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx_q    <= '0;
      my_q    <= '0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      size_q  <= '0;
      bsz_q   <= '0;
      num_q   <= '0;
      rem_x   <= '0;
      rem_y   <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hit     <= 1'b0;
      col     <= '0;
      row     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mx_q    <= mouse_xpos;
          my_q    <= mouse_ypos;
          xpos_q  <= gin.board_xpos;
          ypos_q  <= gin.board_ypos;
          size_q  <= gin.board_size;
          bsz_q   <= gin.button_size;
          num_q   <= gin.button_num;
          col_cnt <= '0;
          row_cnt <= '0;
        end
        CHECK: begin
          rem_x <= dx[XY_W-1:0];
          rem_y <= dy[XY_W-1:0];
        end
        DIV_X: if (x_step) begin
          rem_x   <= rem_x - bsz_q;
          col_cnt <= col_cnt + CNT_W'(1);
        end
        DIV_Y: if (y_step) begin
          rem_y   <= rem_y - bsz_q;
          row_cnt <= row_cnt + CNT_W'(1);
        end
        default: ;
      endcase

      // Outputs are registered against the next state so done lines up with the DONE cycle.
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
      if (state_d == DONE) begin
        hit <= hit_d;
        if (hit_d) begin
          col <= col_cnt;
          row <= row_cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_cell_locator.sv
// Scoreboard bench for cell_locator: a division-based model predicts each click's result and latency.
module tb_cell_locator;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        req;
  logic        busy, done, hit;
  logic [4:0]  col, row;

  game_set_if #(.XY_W(12), .CNT_W(5)) gin_if ();

  cell_locator #(.XY_W(12), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gin        (gin_if),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .req        (req),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .col        (col),
    .row        (row)
  );

  always #5 clk = ~clk;

  typedef struct { int hit; int col; int row; int lat; } exp_t;
  typedef struct { int seen; int lat; int hit; int col; int row; int busy1; int tail; } obs_t;

  int   checks = 0;
  int   failures = 0;
  int   c_xp, c_yp, c_sz, c_bs, c_nm;
  int   prev_col = 0, prev_row = 0;
  exp_t sb[$];

  function automatic exp_t model(int mx, int my);
    exp_t e;
    int dx, dy, c, r;
    dx = mx - c_xp;
    dy = my - c_yp;
    e = '{hit: 0, col: prev_col, row: prev_row, lat: 2};
    if (!(dx < 0 || dy < 0 || dx >= c_sz || dy >= c_sz || c_bs == 0 || c_nm == 0)) begin
      c = dx / c_bs;
      r = dy / c_bs;
      if (c >= c_nm)      e.lat = c_nm + 2;
      else if (r >= c_nm) e.lat = c + c_nm + 3;
      else                e = '{hit: 1, col: c, row: r, lat: c + r + 4};
    end
    return e;
  endfunction

  function automatic string fmt(obs_t o, exp_t e);
    return $sformatf("got seen=%0d lat=%0d hit=%0d col=%0d row=%0d tail=%0d, want lat=%0d hit=%0d col=%0d row=%0d tail=0",
                     o.seen, o.lat, o.hit, o.col, o.row, o.tail, e.lat, e.hit, e.col, e.row);
  endfunction

  task automatic set_cfg(int xp, int yp, int sz, int bs, int nm);
    c_xp = xp; c_yp = yp; c_sz = sz; c_bs = bs; c_nm = nm;
    gin_if.board_xpos  = 12'(xp);
    gin_if.board_ypos  = 12'(yp);
    gin_if.board_size  = 12'(sz);
    gin_if.button_size = 12'(bs);
    gin_if.button_num  = 5'(nm);
  endtask

  task automatic push_expect(int mx, int my);
    exp_t e;
    e = model(mx, my);
    sb.push_back(e);
    if (e.hit != 0) begin
      prev_col = e.col;
      prev_row = e.row;
    end
  endtask

  task automatic drive_req(input int mx, input int my, output obs_t o);
    @(negedge clk);
    mouse_xpos = 12'(mx);
    mouse_ypos = 12'(my);
    req = 1'b1;
    push_expect(mx, my);
    o = '{default: 0};
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (n == 1) o.busy1 = int'(busy);
      if (done) begin
        o = '{seen: 1, lat: n, hit: int'(hit), col: int'(col), row: int'(row), busy1: o.busy1, tail: 0};
        break;
      end
    end
    @(negedge clk);
    o.tail = int'(done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 1'b0;
    mouse_xpos = '0;
    mouse_ypos = '0;
    set_cfg(100, 100, 320, 40, 8);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hit !== 1'b0)  begin failures++; $display("FAIL reset_hit: got %b want 0", hit); end
    checks++; if (col !== 5'd0)  begin failures++; $display("FAIL reset_col: got %0d want 0", col); end
    checks++; if (row !== 5'd0)  begin failures++; $display("FAIL reset_row: got %0d want 0", row); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hit();
    obs_t o; exp_t e;
    drive_req(185, 130, o);
    e = sb.pop_front();
    checks++;
    if (o.seen != 1 || o.lat != e.lat || o.hit != e.hit || o.col != e.col || o.row != e.row || o.tail != 0) begin
      failures++; $display("FAIL hit_185_130: %s", fmt(o, e));
    end
    checks++; if (o.busy1 != 1) begin failures++; $display("FAIL hit_busy: got %0d want 1", o.busy1); end
  endtask

  task automatic test_miss();
    obs_t o; exp_t e;
    drive_req(99, 150, o);
    e = sb.pop_front();
    checks++;
    if (o.seen != 1 || o.lat != e.lat || o.hit != e.hit || o.col != e.col || o.row != e.row || o.tail != 0) begin
      failures++; $display("FAIL miss_left: %s", fmt(o, e));
    end
  endtask

  task automatic test_corner();
    obs_t o; exp_t e;
    int pts[2][2] = '{'{419, 419}, '{420, 419}};
    for (int i = 0; i < 2; i++) begin
      drive_req(pts[i][0], pts[i][1], o);
      e = sb.pop_front();
      checks++;
      if (o.seen != 1 || o.lat != e.lat || o.hit != e.hit || o.col != e.col || o.row != e.row || o.tail != 0) begin
        failures++; $display("FAIL corner_%0d_%0d: %s", pts[i][0], pts[i][1], fmt(o, e));
      end
    end
  endtask

  task automatic test_degenerate();
    obs_t o; exp_t e;
    set_cfg(100, 100, 320, 0, 8);
    drive_req(185, 130, o);
    e = sb.pop_front();
    checks++;
    if (o.seen != 1 || o.lat != e.lat || o.hit != e.hit || o.col != e.col || o.row != e.row || o.tail != 0) begin
      failures++; $display("FAIL zero_button: %s", fmt(o, e));
    end
    set_cfg(100, 100, 320, 40, 4);
    drive_req(270, 110, o);
    e = sb.pop_front();
    checks++;
    if (o.seen != 1 || o.lat != e.lat || o.hit != e.hit || o.col != e.col || o.row != e.row || o.tail != 0) begin
      failures++; $display("FAIL col_limit: %s", fmt(o, e));
    end
    set_cfg(100, 100, 320, 40, 8);
  endtask

  task automatic test_busy();
    obs_t o; exp_t e;
    int extra = 0;
    @(negedge clk);
    mouse_xpos = 12'd419;
    mouse_ypos = 12'd419;
    req = 1'b1;
    push_expect(419, 419);
    o = '{default: 0};
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) req = 1'b0;
      if (n == 3) begin
        req = 1'b1;
        mouse_xpos = 12'd185;
        mouse_ypos = 12'd130;
        gin_if.board_xpos  = 12'd0;
        gin_if.board_ypos  = 12'd0;
        gin_if.board_size  = 12'd100;
        gin_if.button_size = 12'd10;
        gin_if.button_num  = 5'd2;
      end
      if (n == 4) req = 1'b0;
      if (done) begin
        o = '{seen: 1, lat: n, hit: int'(hit), col: int'(col), row: int'(row), busy1: 0, tail: 0};
        break;
      end
    end
    @(negedge clk);
    o.tail = int'(done);
    e = sb.pop_front();
    checks++;
    if (o.seen != 1 || o.lat != e.lat || o.hit != e.hit || o.col != e.col || o.row != e.row || o.tail != 0) begin
      failures++; $display("FAIL busy_ignore: %s", fmt(o, e));
    end
    set_cfg(100, 100, 320, 40, 8);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL busy_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    int seen = 0;
    @(negedge clk);
    mouse_xpos = 12'd419;
    mouse_ypos = 12'd419;
    req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (done) seen++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hit, col, row} !== 13'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b hit=%b col=%0d row=%0d want all 0", busy, done, hit, col, row);
    end
    prev_col = 0;
    prev_row = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen++;
    end
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL reset_mid_no_done: got %0d dones want 0", seen); end
    drive_req(185, 130, o);
    e = sb.pop_front();
    checks++;
    if (o.seen != 1 || o.lat != e.lat || o.hit != e.hit || o.col != e.col || o.row != e.row || o.tail != 0) begin
      failures++; $display("FAIL reset_mid_next: %s", fmt(o, e));
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cnt = 0;
    int want;
`ifdef LOCATOR_EDGE_DETECT_EN
    want = 1;
`else
    want = 3;
`endif
    @(negedge clk);
    mouse_xpos = 12'd185;
    mouse_ypos = 12'd130;
    req = 1'b1;
    for (int i = 0; i < want; i++) push_expect(185, 130);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 20) req = 1'b0;
      if (done) begin
        cnt++;
        if (sb.size() == 0) begin
          failures++; checks++;
          $display("FAIL held_req_unexpected: got done at cycle %0d want none", n);
        end else begin
          e = sb.pop_front();
          checks++;
          if (int'(hit) != e.hit || int'(col) != e.col || int'(row) != e.row) begin
            failures++;
            $display("FAIL held_req_result: got hit=%0d col=%0d row=%0d want hit=%0d col=%0d row=%0d", hit, col, row, e.hit, e.col, e.row);
          end
        end
      end
    end
    checks++; if (cnt != want) begin failures++; $display("FAIL held_req_count: got %0d want %0d", cnt, want); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_corner();
    test_degenerate();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
